// File: rtl/multicycle_control.sv
// multicycle_control
//   Registered multicycle control unit for the 16-bit Cosmic core. Sequences
//   FETCH -> DECODE -> EXECUTE -> (MULDIV | MEMORY) -> WRITEBACK. It stalls
//   on the instruction/data memory ready lines and on the mul/div unit,
//   detects memory timeouts and holds the core in HALT.
//
// Ports
//   clk, rst_n          rising-edge clock, async active-low reset
//   opcode, multi_div   IR fields; sampled at the end of DECODE
//   imem_ready          instruction fetch complete
//   dmem_ready          data access complete
//   muldiv_done         mul/div unit finished (may come early)
//   pc_write, ir_write  PC update strobe (DECODE), IR load strobe (FETCH)
//   alu_*, sign_extend  datapath selects, held EXECUTE..WRITEBACK
//   mem_read/mem_write  data memory strobes (MEMORY)
//   mem_to_reg          writeback source (WRITEBACK, loads)
//   reg_write           00 none, 01 single, 11 mul/div pair
//   jump_branch         000 none, 001 BLT, 010 BGT, 011 BEQ, 100 JMP
//   muldiv_start        one-cycle start pulse (EXECUTE)
//   halted              core halted
//   illegal_op          sticky illegal-opcode flag
//   mem_timeout         sticky memory-timeout flag
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | ir_write, wait for imem_ready (timeout -> HALT)
// DECODE    | pc_write pulse, latch opcode/multi_div
// EXECUTE   | ALU selects, branch strobe or mul/div start
// MULDIV    | wait for muldiv_done or fixed latency
// MEMORY    | mem_read/mem_write until dmem_ready (timeout -> HALT)
// WRITEBACK | reg_write, mem_to_reg for loads
// HALT      | halted, absorbing until reset
module multicycle_control #(
  parameter int OPCODE_W      = 4,
  parameter int MULDIV_CYCLES = 16,
  parameter int MEM_TIMEOUT   = 255,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [1:0]          multi_div,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                muldiv_done,
  output logic                pc_write,
  output logic                ir_write,
  output logic                alu_b_type,
  output logic                alu_src,
  output logic [1:0]          alu_control_op,
  output logic                sign_extend,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic [1:0]          reg_write,
  output logic [2:0]          jump_branch,
  output logic                muldiv_start,
  output logic                halted,
  output logic                illegal_op,
  output logic                mem_timeout
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MULDIV, S_MEMORY, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_BGT   = OPCODE_W'(4'b0100);
  localparam logic [OPCODE_W-1:0] OP_BLT   = OPCODE_W'(4'b0101);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4'b0110);
  localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(4'b0111);
  localparam logic [OPCODE_W-1:0] OP_LBU   = OPCODE_W'(4'b1010);
  localparam logic [OPCODE_W-1:0] OP_SB    = OPCODE_W'(4'b1011);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(4'b1100);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(4'b1101);
  localparam logic [OPCODE_W-1:0] OP_TYPEA = OPCODE_W'(4'b1111);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MULDIV_CYCLES - 1);

  function automatic logic is_load(input logic [OPCODE_W-1:0] o);
    return (o == OP_LBU) || (o == OP_LW);
  endfunction

  function automatic logic is_store(input logic [OPCODE_W-1:0] o);
    return (o == OP_SB) || (o == OP_SW);
  endfunction

  function automatic logic is_branch(input logic [OPCODE_W-1:0] o);
    return (o == OP_BLT) || (o == OP_BGT) || (o == OP_BEQ) || (o == OP_JMP);
  endfunction

  function automatic logic is_legal(input logic [OPCODE_W-1:0] o);
    return is_load(o) || is_store(o) || is_branch(o) || (o == OP_HALT) ||
           (o == OP_ANDI) || (o == OP_ORI) || (o == OP_TYPEA);
  endfunction

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [OPCODE_W-1:0] op_q, op_nxt;
  logic [1:0]          md_q, md_nxt;
  logic                timeout_hit;
  logic                is_muldiv;

  // Outputs are registered from the next state, so they line up with the
  // state register; op_nxt lets the EXECUTE outputs see the opcode being
  // latched on the same edge.
  assign op_nxt    = (state == S_DECODE) ? opcode    : op_q;
  assign md_nxt    = (state == S_DECODE) ? multi_div : md_q;
  assign is_muldiv = (op_nxt == OP_TYPEA) && (md_nxt != 2'b00);

  // State register, wait counter, instruction latch and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      cnt         <= '0;
      op_q        <= '0;
      md_q        <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state <= next_state;
      op_q  <= op_nxt;
      md_q  <= md_nxt;
      if (next_state != state)
        cnt <= '0;
      else if (state != S_HALT)
        cnt <= cnt + 1'b1;
      if ((state == S_DECODE) && !is_legal(opcode))
        illegal_op <= 1'b1;
      if (timeout_hit)
        mem_timeout <= 1'b1;
    end
  end

  // Next-state logic. A fetch is only accepted once ir_write is actually
  // being driven, which matters for the first cycle after reset when the
  // registered strobes are still cleared.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (imem_ready && ir_write) begin
          next_state = S_DECODE;
        end else if (cnt == TO_LAST) begin
          next_state  = S_HALT;
          timeout_hit = 1'b1;
        end
      end
      S_DECODE:
        next_state = is_legal(opcode) ? S_EXECUTE : S_FETCH;
      S_EXECUTE: begin
        if ((op_q == OP_TYPEA) && (md_q != 2'b00))
          next_state = S_MULDIV;
        else if (is_branch(op_q))
          next_state = S_FETCH;
        else if (is_load(op_q) || is_store(op_q))
          next_state = S_MEMORY;
        else if (op_q == OP_HALT)
          next_state = S_HALT;
        else
          next_state = S_WRITEBACK;
      end
      S_MULDIV:
        if (muldiv_done || (cnt == MD_LAST))
          next_state = S_WRITEBACK;
      S_MEMORY: begin
        if (dmem_ready) begin
          next_state = is_load(op_q) ? S_WRITEBACK : S_FETCH;
        end else if (cnt == TO_LAST) begin
          next_state  = S_HALT;
          timeout_hit = 1'b1;
        end
      end
      S_WRITEBACK:
        next_state = S_FETCH;
      S_HALT:
        next_state = S_HALT;
      default:
        next_state = S_FETCH;
    endcase
  end

  // Output decode for the state about to be entered.
  logic       d_pc_write, d_ir_write, d_alu_b_type, d_alu_src, d_sign_extend;
  logic       d_mem_read, d_mem_write, d_mem_to_reg, d_muldiv_start, d_halted;
  logic [1:0] d_alu_control_op, d_reg_write;
  logic [2:0] d_jump_branch;
  logic       alu_phase;

  assign alu_phase = (next_state == S_EXECUTE) || (next_state == S_MULDIV) ||
                     (next_state == S_MEMORY)  || (next_state == S_WRITEBACK);

  always_comb begin
    d_pc_write       = (next_state == S_DECODE);
    d_ir_write       = (next_state == S_FETCH);
    d_alu_b_type     = 1'b0;
    d_alu_src        = 1'b0;
    d_alu_control_op = 2'b00;
    d_sign_extend    = 1'b0;
    d_mem_read       = 1'b0;
    d_mem_write      = 1'b0;
    d_mem_to_reg     = 1'b0;
    d_reg_write      = 2'b00;
    d_jump_branch    = 3'b000;
    d_muldiv_start   = 1'b0;
    d_halted         = (next_state == S_HALT);

    if (alu_phase) begin
      if (is_load(op_nxt) || is_store(op_nxt)) begin
        d_alu_b_type     = 1'b1;
        d_alu_src        = 1'b1;
        d_alu_control_op = 2'b10;
        d_sign_extend    = (op_nxt == OP_LBU);
      end else if (op_nxt == OP_ANDI) begin
        d_alu_src        = 1'b1;
        d_alu_control_op = 2'b01;
      end else if (op_nxt == OP_ORI) begin
        d_alu_src        = 1'b1;
        d_alu_control_op = 2'b11;
      end
    end

    if (next_state == S_EXECUTE) begin
      d_muldiv_start = is_muldiv;
      if (op_nxt == OP_BLT)      d_jump_branch = 3'b001;
      else if (op_nxt == OP_BGT) d_jump_branch = 3'b010;
      else if (op_nxt == OP_BEQ) d_jump_branch = 3'b011;
      else if (op_nxt == OP_JMP) d_jump_branch = 3'b100;
    end

    if (next_state == S_MEMORY) begin
      d_mem_read  = is_load(op_nxt);
      d_mem_write = is_store(op_nxt);
    end

    if (next_state == S_WRITEBACK) begin
      d_mem_to_reg = is_load(op_nxt);
      d_reg_write  = is_muldiv ? 2'b11 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_write       <= 1'b0;
      ir_write       <= 1'b0;
      alu_b_type     <= 1'b0;
      alu_src        <= 1'b0;
      alu_control_op <= 2'b00;
      sign_extend    <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_to_reg     <= 1'b0;
      reg_write      <= 2'b00;
      jump_branch    <= 3'b000;
      muldiv_start   <= 1'b0;
      halted         <= 1'b0;
    end else begin
      pc_write       <= d_pc_write;
      ir_write       <= d_ir_write;
      alu_b_type     <= d_alu_b_type;
      alu_src        <= d_alu_src;
      alu_control_op <= d_alu_control_op;
      sign_extend    <= d_sign_extend;
      mem_read       <= d_mem_read;
      mem_write      <= d_mem_write;
      mem_to_reg     <= d_mem_to_reg;
      reg_write      <= d_reg_write;
      jump_branch    <= d_jump_branch;
      muldiv_start   <= d_muldiv_start;
      halted         <= d_halted;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (default parameters).
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic [1:0] multi_div;
  logic       imem_ready, dmem_ready, muldiv_done;
  logic       pc_write, ir_write, alu_b_type, alu_src, sign_extend;
  logic       mem_read, mem_write, mem_to_reg, muldiv_start, halted;
  logic       illegal_op, mem_timeout;
  logic [1:0] alu_control_op, reg_write;
  logic [2:0] jump_branch;

  int n_assert = 0;
  int n_fail   = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .multi_div(multi_div),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .muldiv_done(muldiv_done),
    .pc_write(pc_write), .ir_write(ir_write), .alu_b_type(alu_b_type),
    .alu_src(alu_src), .alu_control_op(alu_control_op), .sign_extend(sign_extend),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .jump_branch(jump_branch), .muldiv_start(muldiv_start),
    .halted(halted), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Packed view of all outputs and one-hot field constants for expectations.
  logic [18:0] obs;
  assign obs = {pc_write, ir_write, alu_b_type, alu_src, alu_control_op,
                sign_extend, mem_read, mem_write, mem_to_reg, reg_write,
                jump_branch, muldiv_start, halted, illegal_op, mem_timeout};

  localparam logic [18:0] NONE  = 19'd0;
  localparam logic [18:0] PC    = 19'(1) << 18;
  localparam logic [18:0] IR    = 19'(1) << 17;
  localparam logic [18:0] BT    = 19'(1) << 16;
  localparam logic [18:0] SRC   = 19'(1) << 15;
  localparam logic [18:0] OP01  = 19'(1) << 13;
  localparam logic [18:0] OP10  = 19'(2) << 13;
  localparam logic [18:0] OP11  = 19'(3) << 13;
  localparam logic [18:0] SE    = 19'(1) << 12;
  localparam logic [18:0] MR    = 19'(1) << 11;
  localparam logic [18:0] MW    = 19'(1) << 10;
  localparam logic [18:0] M2R   = 19'(1) << 9;
  localparam logic [18:0] RW01  = 19'(1) << 7;
  localparam logic [18:0] RW11  = 19'(3) << 7;
  localparam logic [18:0] JB011 = 19'(3) << 4;
  localparam logic [18:0] MS    = 19'(1) << 3;
  localparam logic [18:0] HLT   = 19'(1) << 2;
  localparam logic [18:0] IL    = 19'(1) << 1;
  localparam logic [18:0] MT    = 19'(1);

  task automatic check(input string tag, input logic [18:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'b0000; multi_div = 2'b00;
    imem_ready = 1'b1; dmem_ready = 1'b0; muldiv_done = 1'b0;
    #3 check("reset", NONE);
    @(negedge clk) rst_n = 1'b1;
    tick(); check("fetch0", IR);

    // ORI: FETCH -> DECODE -> EXECUTE -> WRITEBACK
    opcode = 4'b0010;
    tick(); check("ori_dec", PC);
    tick(); check("ori_exe", SRC | OP11);
    tick(); check("ori_wb", SRC | OP11 | RW01);
    tick(); check("ori_fetch", IR);

    // Type A mul/div, full latency
    opcode = 4'b1111; multi_div = 2'b01;
    tick(); check("md_dec", PC);
    tick(); check("md_exe", MS);
    for (int i = 0; i < 16; i++) begin
      tick(); check("md_wait", NONE);
    end
    tick(); check("md_wb", RW11);
    tick(); check("md_fetch", IR);

    // Type A mul/div, done in the third wait cycle
    tick(); check("md2_dec", PC);
    tick(); check("md2_exe", MS);
    tick(); check("md2_w1", NONE);
    tick(); check("md2_w2", NONE);
    tick(); check("md2_w3", NONE);
    muldiv_done = 1'b1;
    tick(); check("md2_wb", RW11);
    muldiv_done = 1'b0; multi_div = 2'b00;
    tick(); check("md2_fetch", IR);

    // LBU with dmem_ready arriving in the sixth MEMORY cycle
    opcode = 4'b1010;
    tick(); check("lbu_dec", PC);
    tick(); check("lbu_exe", BT | SRC | OP10 | SE);
    for (int i = 1; i <= 6; i++) begin
      tick(); check("lbu_mem", BT | SRC | OP10 | SE | MR);
    end
    dmem_ready = 1'b1;
    tick(); check("lbu_wb", BT | SRC | OP10 | SE | M2R | RW01);
    dmem_ready = 1'b0;
    tick(); check("lbu_fetch", IR);

    // SW with ready on MEMORY entry, then BEQ
    opcode = 4'b1101;
    tick(); check("sw_dec", PC);
    tick(); check("sw_exe", BT | SRC | OP10);
    dmem_ready = 1'b1;
    tick(); check("sw_mem", BT | SRC | OP10 | MW);
    tick(); check("sw_fetch", IR);
    dmem_ready = 1'b0;
    opcode = 4'b0110;
    tick(); check("beq_dec", PC);
    tick(); check("beq_exe", JB011);
    tick(); check("beq_fetch", IR);

    // ANDI
    opcode = 4'b0001;
    tick(); check("andi_dec", PC);
    tick(); check("andi_exe", SRC | OP01);
    tick(); check("andi_wb", SRC | OP01 | RW01);
    tick(); check("andi_fetch", IR);

    // Illegal opcode, then LW that times out
    opcode = 4'b0011;
    tick(); check("ill_dec", PC);
    tick(); check("ill_fetch", IR | IL);
    opcode = 4'b1100;
    tick(); check("lw_dec", PC | IL);
    tick(); check("lw_exe", BT | SRC | OP10 | IL);
    for (int i = 1; i <= 255; i++) begin
      tick(); check("lw_mem_wait", BT | SRC | OP10 | MR | IL);
    end
    tick(); check("timeout_halt", HLT | IL | MT);
    for (int i = 0; i < 5; i++) begin
      tick(); check("timeout_stay", HLT | IL | MT);
    end

    // Reset out of HALT clears flags
    #2 rst_n = 1'b0;
    #1 check("reset_halt", NONE);
    @(negedge clk) rst_n = 1'b1;
    tick(); check("fetch_rst", IR);

    // Asynchronous reset in the middle of MEMORY
    tick(); check("lw2_dec", PC);
    tick(); check("lw2_exe", BT | SRC | OP10);
    tick(); check("lw2_mem1", BT | SRC | OP10 | MR);
    tick(); check("lw2_mem2", BT | SRC | OP10 | MR);
    #3 rst_n = 1'b0;
    #2 check("reset_mid_mem", NONE);
    @(negedge clk) rst_n = 1'b1;
    tick(); check("fetch_rst2", IR);

    // HALT opcode is absorbing
    opcode = 4'b0000;
    tick(); check("halt_dec", PC);
    tick(); check("halt_exe", NONE);
    tick(); check("halt_enter", HLT);
    for (int i = 0; i < 100; i++) begin
      tick(); check("halt_stay", HLT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
